// File: rtl/cm0ik_gpio_pkg.sv
// Shared constants and helpers for the cm0ik GPIO slave: word offsets,
// interrupt-type encoding and AHB byte-lane decode.
package cm0ik_gpio_pkg;

  localparam int OFF_W = 10;

  localparam logic [OFF_W-1:0] OFF_DATA    = 10'h000;
  localparam logic [OFF_W-1:0] OFF_DATAOUT = 10'h001;
  localparam logic [OFF_W-1:0] OFF_OUTSET  = 10'h002;
  localparam logic [OFF_W-1:0] OFF_OUTCLR  = 10'h003;
  localparam logic [OFF_W-1:0] OFF_DIR     = 10'h004;
  localparam logic [OFF_W-1:0] OFF_INTEN   = 10'h005;
  localparam logic [OFF_W-1:0] OFF_INTTYPE = 10'h006;
  localparam logic [OFF_W-1:0] OFF_INTPOL  = 10'h007;
  localparam logic [OFF_W-1:0] OFF_INTSTAT = 10'h008;
  localparam logic [OFF_W-1:0] OFF_INTBOTH = 10'h009;

  localparam logic INTTYPE_LEVEL = 1'b0;
  localparam logic INTTYPE_EDGE  = 1'b1;

  function automatic logic [3:0] byte_lanes(input logic [2:0] hsize,
                                            input logic [1:0] addr);
    logic [3:0] lanes;
    case (hsize)
      3'b000:  lanes = 4'b0001 << addr;
      3'b001:  lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{lanes[i]}};
    return m;
  endfunction

endpackage

// File: rtl/cm0ik_gpio_sync.sv
// Pad-input synchroniser plus previous-sample register; produces the
// synchronised value and single-cycle rise/fall indications.
module cm0ik_gpio_sync
  import cm0ik_gpio_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_in};
    prev_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_in = chain_q[STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/cm0ik_gpio_ext.sv
// AHB-Lite GPIO slave: zero-wait register file, atomic set/clear, per-pin
// level/edge interrupts. CM0IK_GPIO_BOTHEDGE_EN adds the INTBOTH register.
module cm0ik_gpio_ext
  import cm0ik_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [11:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [GPIO_WIDTH-1:0] GPIOIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [GPIO_WIDTH-1:0] GPIOOUT,
  output logic [GPIO_WIDTH-1:0] GPIOEN,
  output logic [GPIO_WIDTH-1:0] GPIOINTS,
  output logic                  GPIOINT
);

  localparam int W = GPIO_WIDTH;

  logic             wr_q, wr_d, rd_q, rd_d;
  logic [3:0]       lanes_q, lanes_d;
  logic [OFF_W-1:0] off_q, off_d;

  logic [W-1:0] dout_q, dout_d, dir_q, dir_d, inten_q, inten_d;
  logic [W-1:0] itype_q, itype_d, ipol_q, ipol_d, istat_q, istat_d;
  logic [W-1:0] both_mode;

  logic [W-1:0] sync_in, rise, fall;
  logic [W-1:0] edge_mode, lvl_hit, pol_hit, edg_hit, set_vec;
  logic [W-1:0] bm, wbits, w1c, rdata_w;
  logic [31:0]  bm_full;
  logic         unused_ok;

  cm0ik_gpio_sync #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_sync (
    .clk      (HCLK),
    .rst      (HRESET),
    .async_in (GPIOIN),
    .sync_in  (sync_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Address phase is only sampled when the bus is ready; otherwise hold.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    lanes_d = lanes_q;
    off_d   = off_q;
    if (HREADY) begin
      wr_d    = HSEL & HTRANS[1] & HWRITE;
      rd_d    = HSEL & HTRANS[1] & ~HWRITE;
      lanes_d = byte_lanes(HSIZE, HADDR[1:0]);
      off_d   = HADDR[11:2];
    end
  end

  assign bm_full = lane_mask(lanes_q);
  assign bm      = bm_full[W-1:0];
  assign wbits   = HWDATA[W-1:0] & bm;

`ifdef CM0IK_GPIO_BOTHEDGE_EN
  logic [W-1:0] iboth_q, iboth_d;
  assign both_mode = iboth_q;
`else
  assign both_mode = '0;
`endif

  // Set wins over a same-cycle W1C so an active level stays pending.
  assign edge_mode = {W{INTTYPE_EDGE}} ~^ itype_q;
  assign lvl_hit   = ~edge_mode & ~(sync_in ^ ipol_q);
  assign pol_hit   = (ipol_q & rise) | (~ipol_q & fall);
  assign edg_hit   = edge_mode & ((both_mode & (rise | fall)) | (~both_mode & pol_hit));
  assign set_vec   = ~dir_q & (lvl_hit | edg_hit);

  always_comb begin
    dout_d  = dout_q;
    dir_d   = dir_q;
    inten_d = inten_q;
    itype_d = itype_q;
    ipol_d  = ipol_q;
    w1c     = '0;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
    iboth_d = iboth_q;
`endif
    if (wr_q) begin
      case (off_q)
        OFF_DATA, OFF_DATAOUT: dout_d = (dout_q & ~bm) | wbits;
        OFF_OUTSET:  dout_d  = dout_q | wbits;
        OFF_OUTCLR:  dout_d  = dout_q & ~wbits;
        OFF_DIR:     dir_d   = (dir_q & ~bm) | wbits;
        OFF_INTEN:   inten_d = (inten_q & ~bm) | wbits;
        OFF_INTTYPE: itype_d = (itype_q & ~bm) | wbits;
        OFF_INTPOL:  ipol_d  = (ipol_q & ~bm) | wbits;
        OFF_INTSTAT: w1c     = wbits;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
        OFF_INTBOTH: iboth_d = (iboth_q & ~bm) | wbits;
`endif
        default: ;
      endcase
    end
    istat_d = (istat_q & ~w1c) | set_vec;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      lanes_q <= '0;
      off_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      inten_q <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      istat_q <= '0;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
      iboth_q <= '0;
`endif
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lanes_q <= lanes_d;
      off_q   <= off_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      inten_q <= inten_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      istat_q <= istat_d;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
      iboth_q <= iboth_d;
`endif
    end
  end

  always_comb begin
    rdata_w = '0;
    if (rd_q) begin
      case (off_q)
        OFF_DATA:    rdata_w = sync_in;
        OFF_DATAOUT: rdata_w = dout_q;
        OFF_DIR:     rdata_w = dir_q;
        OFF_INTEN:   rdata_w = inten_q;
        OFF_INTTYPE: rdata_w = itype_q;
        OFF_INTPOL:  rdata_w = ipol_q;
        OFF_INTSTAT: rdata_w = istat_q;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
        OFF_INTBOTH: rdata_w = iboth_q;
`endif
        default:     rdata_w = '0;
      endcase
    end
    HRDATA        = '0;
    HRDATA[W-1:0] = rdata_w;
  end

  assign GPIOOUT   = dout_q;
  assign GPIOEN    = dir_q;
  assign GPIOINTS  = istat_q & inten_q;
  assign GPIOINT   = |GPIOINTS;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign unused_ok = ^{HTRANS[0], HWDATA, bm_full, OFF_INTBOTH, INTTYPE_LEVEL};

endmodule

// File: tb/tb_cm0ik_gpio_ext.sv
// Bench for cm0ik_gpio_ext: directed register-map/interrupt steps followed by
// random bus traffic and pad activity checked against a register-level model.
module tb_cm0ik_gpio_ext;

  localparam int W = 32;
  localparam int S = 2;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY;
  logic [11:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic [W-1:0]  GPIOIN;
  logic          HREADYOUT, HRESP, GPIOINT;
  logic [31:0]   HRDATA;
  logic [W-1:0]  GPIOOUT, GPIOEN, GPIOINTS;

  cm0ik_gpio_ext #(.GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .GPIOIN(GPIOIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .GPIOOUT(GPIOOUT), .GPIOEN(GPIOEN), .GPIOINTS(GPIOINTS), .GPIOINT(GPIOINT)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Reference state: register contents, pad samples (hist[0] newest) and the
  // transfer awaiting its data phase.
  logic [31:0] m_out, m_dir, m_en, m_type, m_pol, m_both, m_stat;
  logic [31:0] hist [0:S];
  logic        p_wr, p_rd;
  logic [9:0]  p_off;
  logic [31:0] p_mask;

  function automatic logic [31:0] size_mask(input logic [2:0] sz, input logic [1:0] a);
    if (sz == 3'd0) return 32'hFF << (8 * a);
    if (sz == 3'd1) return 32'hFFFF << (16 * a[1]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_read();
    if (!p_rd) return 32'h0;
    case (p_off)
      10'd0: return hist[S-1];
      10'd1: return m_out;
      10'd4: return m_dir;
      10'd5: return m_en;
      10'd6: return m_type;
      10'd7: return m_pol;
      10'd8: return m_stat;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
      10'd9: return m_both;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] cur, prv, setv, w1c, wd;
    if (HRESET) begin
      {m_out, m_dir, m_en, m_type, m_pol, m_both, m_stat} = '0;
      for (int k = 0; k <= S; k++) hist[k] = '0;
      p_wr = 1'b0; p_rd = 1'b0; p_off = '0; p_mask = '0;
      return;
    end
    cur = hist[S-1];
    prv = hist[S];
    setv = '0;
    for (int i = 0; i < W; i++) begin
      if (!m_dir[i]) begin
        if (!m_type[i])     setv[i] = (cur[i] == m_pol[i]);
        else if (m_both[i]) setv[i] = (cur[i] != prv[i]);
        else if (m_pol[i])  setv[i] = cur[i] && !prv[i];
        else                setv[i] = !cur[i] && prv[i];
      end
    end
    w1c = '0;
    if (p_wr) begin
      wd = HWDATA & p_mask;
      case (p_off)
        10'd0, 10'd1: m_out = (m_out & ~p_mask) | wd;
        10'd2: m_out = m_out | wd;
        10'd3: m_out = m_out & ~wd;
        10'd4: m_dir  = (m_dir  & ~p_mask) | wd;
        10'd5: m_en   = (m_en   & ~p_mask) | wd;
        10'd6: m_type = (m_type & ~p_mask) | wd;
        10'd7: m_pol  = (m_pol  & ~p_mask) | wd;
        10'd8: w1c = wd;
`ifdef CM0IK_GPIO_BOTHEDGE_EN
        10'd9: m_both = (m_both & ~p_mask) | wd;
`endif
        default: ;
      endcase
    end
    m_stat = (m_stat & ~w1c) | setv;
    p_wr   = HREADY && HSEL && HTRANS[1] && HWRITE;
    p_rd   = HREADY && HSEL && HTRANS[1] && !HWRITE;
    p_off  = HADDR[11:2];
    p_mask = size_mask(HSIZE, HADDR[1:0]);
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = GPIOIN;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_outs();
    chk("gpioout",  GPIOOUT, m_out);
    chk("gpioen",   GPIOEN, m_dir);
    chk("gpioints", GPIOINTS, m_stat & m_en);
    chk("gpioint",  32'(GPIOINT), 32'(|(m_stat & m_en)));
    chk("hrdata",   HRDATA, model_read());
  endtask

  task automatic addr_ph(input logic wr, input logic [11:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d);
    addr_ph(1'b1, a, sz); tick();
    idle(); HWDATA = d; tick();
  endtask

  task automatic rd_model(input logic [11:0] a, input string tag);
    addr_ph(1'b0, a, 3'd2); tick();
    idle(); chk(tag, HRDATA, model_read()); tick();
  endtask

  task automatic rd_const(input logic [11:0] a, input string tag, input logic [31:0] exp);
    addr_ph(1'b0, a, 3'd2); tick();
    idle(); chk(tag, HRDATA, exp); tick();
  endtask

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HWDATA = '0; HADDR = '0; HSIZE = 3'd2;
    GPIOIN = '0; idle();
    repeat (3) tick();
    HRESET = 1'b0;

    chk("rst_gpioout", GPIOOUT, 32'h0);
    chk("rst_gpioen", GPIOEN, 32'h0);
    chk("rst_gpioints", GPIOINTS, 32'h0);
    chk("rst_gpioint", 32'(GPIOINT), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);

    rd_const(12'h000, "rst_data", 32'h0);
    rd_const(12'h004, "rst_dataout", 32'h0);
    rd_const(12'h010, "rst_dir", 32'h0);
    // Level-low is the reset detection mode, so low pads make INTSTATUS pend.
    for (int o = 0; o <= 10; o++) rd_model(12'(o * 4), "rst_offset");

    wr(12'h004, 3'd2, 32'h0000_00F0);
    wr(12'h008, 3'd2, 32'h0000_0003);
    wr(12'h00C, 3'd2, 32'h0000_0010);
    chk("setclr_gpioout", GPIOOUT, 32'h0000_00E3);
    rd_const(12'h004, "setclr_dataout", 32'h0000_00E3);
    rd_const(12'h008, "outset_reads0", 32'h0);

    wr(12'h010, 3'd2, 32'h1111_1111);
    wr(12'h012, 3'd0, 32'h00AB_0000);
    rd_const(12'h010, "dir_byte", 32'h11AB_1111);
    chk("dir_gpioen", GPIOEN, 32'h11AB_1111);
    wr(12'h010, 3'd2, 32'h0);

    addr_ph(1'b1, 12'h004, 3'd2); tick();
    HWDATA = 32'h1234_5678; addr_ph(1'b0, 12'h004, 3'd2); tick();
    idle(); chk("b2b_wr_rd", HRDATA, 32'h1234_5678); tick();
    wr(12'h004, 3'd2, 32'h0);

    GPIOIN = ~32'h10;
    wr(12'h018, 3'd2, 32'h10);
    wr(12'h01C, 3'd2, 32'h10);
    wr(12'h014, 3'd2, 32'h10);
    wr(12'h020, 3'd2, 32'hFFFF_FFFF);
    rd_const(12'h020, "edge_clean", 32'h0);
    GPIOIN = '1; tick();
    GPIOIN = ~32'h10;
    repeat (S - 1) tick();
    chk("edge_int_early", 32'(GPIOINT), 32'h0);
    tick();
    chk("edge_int_on", 32'(GPIOINT), 32'h1);
    chk("edge_ints", GPIOINTS, 32'h10);
    repeat (3) tick();
    rd_const(12'h020, "edge_status", 32'h10);
    wr(12'h020, 3'd2, 32'h10);
    rd_const(12'h020, "edge_w1c", 32'h0);
    chk("edge_int_off", 32'(GPIOINT), 32'h0);

    GPIOIN = ~32'h11;
    repeat (3) tick();
    wr(12'h020, 3'd2, 32'h1);
    rd_const(12'h020, "level_sticky", 32'h1);
    GPIOIN = ~32'h10;
    repeat (3) tick();
    wr(12'h020, 3'd2, 32'h1);
    rd_const(12'h020, "level_clear", 32'h0);

`ifdef CM0IK_GPIO_BOTHEDGE_EN
    wr(12'h018, 3'd2, 32'h90);
    wr(12'h01C, 3'd2, 32'h90);
    wr(12'h024, 3'd2, 32'h80);
    rd_const(12'h024, "intboth_rw", 32'h80);
    wr(12'h020, 3'd2, 32'hFFFF_FFFF);
    rd_const(12'h020, "both_clean", 32'h0);
    GPIOIN = ~32'h90; repeat (4) tick();
    rd_const(12'h020, "both_fall", 32'h80);
    wr(12'h020, 3'd2, 32'h80);
    GPIOIN = ~32'h10; repeat (4) tick();
    rd_const(12'h020, "both_rise", 32'h80);
`else
    wr(12'h024, 3'd2, 32'hFFFF_FFFF);
    rd_const(12'h024, "off24_unmapped", 32'h0);
`endif

    addr_ph(1'b1, 12'h004, 3'd2); tick();
    idle(); HWDATA = 32'h55; HRESET = 1'b1; tick();
    HRESET = 1'b0;
    chk("midxfer_rst_out", GPIOOUT, 32'h0);
    chk("midxfer_rst_rd", HRDATA, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [9:0] off;
      logic [2:0] sz;
      logic [1:0] lo;
      GPIOIN = GPIOIN ^ ($urandom & $urandom & $urandom);
      HWDATA = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        off = 10'($urandom_range(0, 12));
        sz  = 3'($urandom_range(0, 2));
        lo  = (sz == 3'd0) ? 2'($urandom_range(0, 3)) : (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
        HSEL   = ($urandom_range(0, 7) != 0);
        HTRANS = ($urandom_range(0, 7) != 0) ? 2'b10 : 2'b01;
        HWRITE = 1'($urandom_range(0, 1));
        HADDR  = {off, lo};
        HSIZE  = sz;
      end else begin
        idle();
      end
      tick();
      chk_outs();
    end
    idle(); tick();
    chk_outs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
